// File: rtl/uart_pkg.sv
// Shared UART definitions: baud constants, oversampling and frame geometry,
// vote sample offsets, receiver FSM encoding and the baud divisor helper.
`timescale 1ns/1ps
package uart_pkg;

  localparam int BAUD_9600   = 9600;
  localparam int BAUD_19200  = 19200;
  localparam int BAUD_38400  = 38400;
  localparam int BAUD_57600  = 57600;
  localparam int BAUD_115200 = 115200;

  localparam int OVERSAMPLE  = 16;
  localparam int FRAME_BITS  = 10;

  // Ticks within a bit at which the line is sampled for the 2-of-3 vote
  localparam logic [3:0] SAMPLE_OFS_A = 4'd6;
  localparam logic [3:0] SAMPLE_OFS_B = 4'd7;
  localparam logic [3:0] SAMPLE_OFS_C = 4'd8;

  localparam logic [3:0] STOP_BIT_IDX     = 4'(FRAME_BITS - 1);
  localparam logic [7:0] STOP_DECIDE_TCNT = 8'(OVERSAMPLE * (FRAME_BITS - 1)) + {4'd0, SAMPLE_OFS_C};

  localparam int DIV_W = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } rx_state_e;

  // Truncated clocks-per-tick for a given line rate
  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// 16x oversampling tick divider. The counter runs 0..DIV-1 and pulses tick
// on DIV-1; clr restarts the count so the first tick lands DIV clocks later.
`timescale 1ns/1ps
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic [2:0] baud_sel,
  output logic       tick
);

  localparam logic [DIV_W-1:0] DIVM1_9600   = DIV_W'(baud_div(CLK_FREQ_HZ, BAUD_9600) - 1);
  localparam logic [DIV_W-1:0] DIVM1_19200  = DIV_W'(baud_div(CLK_FREQ_HZ, BAUD_19200) - 1);
  localparam logic [DIV_W-1:0] DIVM1_38400  = DIV_W'(baud_div(CLK_FREQ_HZ, BAUD_38400) - 1);
  localparam logic [DIV_W-1:0] DIVM1_57600  = DIV_W'(baud_div(CLK_FREQ_HZ, BAUD_57600) - 1);
  localparam logic [DIV_W-1:0] DIVM1_115200 = DIV_W'(baud_div(CLK_FREQ_HZ, BAUD_115200) - 1);

  logic [DIV_W-1:0] div_m1;
  logic [DIV_W-1:0] cnt_q, cnt_d;

  // Terminal count select; unused codes fall back to 9600
  always_comb begin
    case (baud_sel)
      3'd1:    div_m1 = DIVM1_19200;
      3'd2:    div_m1 = DIVM1_38400;
      3'd3:    div_m1 = DIVM1_57600;
      3'd4:    div_m1 = DIVM1_115200;
      default: div_m1 = DIVM1_9600;
    endcase
  end

  // Tick on terminal count, wrap to zero, clear has priority
  always_comb begin
    tick  = !clr && (cnt_q == div_m1);
    cnt_d = (clr || tick) ? '0 : cnt_q + DIV_W'(1);
  end

  // Divider counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_byte_rx.sv
// UART 8N1 byte receiver with 16x oversampling and 2-of-3 majority vote per
// bit. Stop bit is judged mid-bit so back-to-back frames are accepted.
// Optional macro UART_RX_FRAME_CHECK_EN: a low stop bit pulses frame_err and
// suppresses rx_done; without it the stop bit is ignored.
`timescale 1ns/1ps
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  input  logic [2:0] baud_set,
  output logic [7:0] data_byte,
  output logic       rx_done,
  output logic       uart_state,
  output logic       frame_err
);

  logic       rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  logic       fall_edge, start, tick, decide, maj;
  logic [3:0] bit_idx;
  rx_state_e  state_q, state_d;
  logic [2:0] baud_q, baud_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic [1:0] smp_q, smp_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] data_q, data_d;
  logic       done_q, done_d;
`ifdef UART_RX_FRAME_CHECK_EN
  logic       ferr_q, ferr_d;
`endif

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  uart_baud_tick #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
    .clk      (clk),
    .reset    (reset),
    .clr      (start),
    .baud_sel (baud_q),
    .tick     (tick)
  );

  // Synchroniser chain plus previous-value register for edge detection
  always_comb begin
    rx_s1_d   = uart_rx;
    rx_s2_d   = rx_s1_q;
    rx_prev_d = rx_s2_q;
    fall_edge = rx_prev_q && !rx_s2_q;
    start     = (state_q == ST_IDLE) && fall_edge;
    bit_idx   = tcnt_q[7:4];
    decide    = (state_q == ST_RECV) && tick && (tcnt_q[3:0] == SAMPLE_OFS_C);
    maj       = majority3(smp_q[0], smp_q[1], rx_s2_q);
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: leave on false start or after the stop-bit vote
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (fall_edge) state_d = ST_RECV;
      ST_RECV: begin
        if (decide && bit_idx == 4'd0 && maj)      state_d = ST_IDLE;
        else if (decide && bit_idx == STOP_BIT_IDX) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: tick counting, vote sampling, shifting and byte delivery
  always_comb begin
    baud_d  = baud_q;
    tcnt_d  = tcnt_q;
    smp_d   = smp_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    done_d  = 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
    ferr_d  = 1'b0;
`endif
    if (start) begin
      baud_d = baud_set;
      tcnt_d = '0;
    end
    if (state_q == ST_RECV && tick) begin
      tcnt_d = tcnt_q + 8'd1;
      if (tcnt_q[3:0] == SAMPLE_OFS_A) smp_d[0] = rx_s2_q;
      if (tcnt_q[3:0] == SAMPLE_OFS_B) smp_d[1] = rx_s2_q;
    end
    if (decide && bit_idx >= 4'd1 && bit_idx <= 4'd8)
      shreg_d[3'(bit_idx - 4'd1)] = maj;
    if (decide && tcnt_q == STOP_DECIDE_TCNT) begin
`ifdef UART_RX_FRAME_CHECK_EN
      if (maj) begin
        data_d = shreg_q;
        done_d = 1'b1;
      end else begin
        ferr_d = 1'b1;
      end
`else
      data_d = shreg_q;
      done_d = 1'b1;
`endif
    end
  end

  // Control and output registers, cleared by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      baud_q    <= '0;
      tcnt_q    <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
      ferr_q    <= 1'b0;
`endif
    end else begin
      rx_s1_q   <= rx_s1_d;
      rx_s2_q   <= rx_s2_d;
      rx_prev_q <= rx_prev_d;
      baud_q    <= baud_d;
      tcnt_q    <= tcnt_d;
      data_q    <= data_d;
      done_q    <= done_d;
`ifdef UART_RX_FRAME_CHECK_EN
      ferr_q    <= ferr_d;
`endif
    end
  end

  // Vote samples and shift register; every bit is rewritten each frame
  always_ff @(posedge clk) begin
    smp_q   <= smp_d;
    shreg_q <= shreg_d;
  end

  assign data_byte  = data_q;
  assign rx_done    = done_q;
  assign uart_state = (state_q == ST_RECV);
`ifdef UART_RX_FRAME_CHECK_EN
  assign frame_err  = ferr_q;
`else
  assign frame_err  = 1'b0;
`endif

endmodule
